// File: rtl/uart_tx_if.sv
// Upstream word handshake for uart_tx: the source drives data/valid, the transmitter drives ready.
interface uart_tx_if #(
  parameter int unsigned DATA_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_valid;
  logic                  data_ready;

  modport master (
    output data_in,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH bits LSB-first, STOP_BITS stop bits, one-word hold buffer.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module uart_tx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  uart_tx_if.slave   up_if,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam int unsigned T    = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CntW = (T > 1) ? $clog2(T) : 1;
  localparam int unsigned BitW = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef UART_TX_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [BitW-1:0]       bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic                  tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  logic hs, cnt_last, last_data, last_stop, frame_end, load_direct, load_hold;

  assign up_if.data_ready = ~hold_full_q;
  assign hs        = up_if.data_valid & ~hold_full_q;
  assign cnt_last  = (cnt_q == CntW'(T - 1));
  assign last_data = (bit_q == BitW'(DATA_WIDTH - 1));
  assign last_stop = (bit_q == BitW'(STOP_BITS - 1));
  assign frame_end = (state_q == StStop) & cnt_last & last_stop;

  // A word goes straight to the shifter when the line is free now or frees on this edge.
  assign load_direct = hs & ((state_q == StIdle) | (frame_end & ~hold_full_q));
  assign load_hold   = frame_end & hold_full_q;

  assign tx_o   = tx_q;
  assign busy_o = (state_q != StIdle);
  assign done_o = frame_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (hs) state_d = StStart;
      StStart: if (cnt_last) state_d = StData;
      StData: begin
        if (cnt_last && last_data) begin
`ifdef UART_TX_PARITY_EN
          state_d = StParity;
`else
          state_d = StStop;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      StParity: if (cnt_last) state_d = StStop;
`endif
      StStop: begin
        if (frame_end) state_d = (hold_full_q || hs) ? StStart : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if (state_q != StIdle && !cnt_last) cnt_d = cnt_q + 1'b1;

    // bit_q indexes data bits in StData and stop bits in StStop.
    bit_d = bit_q;
    if (state_q == StIdle) begin
      bit_d = '0;
    end else if (cnt_last) begin
      if ((state_q == StData && !last_data) || (state_q == StStop && !last_stop)) begin
        bit_d = bit_q + 1'b1;
      end else begin
        bit_d = '0;
      end
    end

    shift_d = shift_q;
    if (load_direct) begin
      shift_d = up_if.data_in;
    end else if (load_hold) begin
      shift_d = hold_q;
    end else if (state_q == StData && cnt_last) begin
      shift_d = shift_q >> 1;
    end

    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (load_hold) begin
      hold_full_d = 1'b0;
    end else if (hs && !load_direct) begin
      hold_d      = up_if.data_in;
      hold_full_d = 1'b1;
    end

`ifdef UART_TX_PARITY_EN
    par_d = par_q;
    if (load_direct) begin
      par_d = ^up_if.data_in;
    end else if (load_hold) begin
      par_d = ^hold_q;
    end
`endif

    // tx is registered, so it is decoded from the state being entered.
    tx_d = 1'b1;
    unique case (state_d)
      StIdle:   tx_d = 1'b1;
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      StParity: tx_d = par_q;
`endif
      StStop:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q       <= 1'b0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q       <= par_d;
`endif
    end
  end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART transmitter; the transmit-side counterpart of the team's UART receiver.
- Serialises parallel words from an upstream source, such as a DDR read-back or unpacker stage, onto a single TX line.
- Frame format: 1 start bit (low), DATA_WIDTH data bits LSB-first, then STOP_BITS stop bits (high).
- A one-entry holding register allows back-to-back frames with zero idle cycles between them.

Parameters:
- DATA_WIDTH, 8, data bits per frame.
- CLK_FREQ, 100_000_000, clk frequency in Hz.
- BAUD_RATE, 115200, line rate in bits/s; bit period T = CLK_FREQ/BAUD_RATE (integer division), at least 2.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  DATA_WIDTH  word to transmit; sampled on handshake.
- data_valid  input  1  upstream has a word on data_in.
- data_ready  output  1  block can accept a word; handshake = data_valid & data_ready at a clk edge.
- tx  output  1  serial line, registered, idles high.
- busy  output  1  a frame is on the line.
- done  output  1  one-cycle pulse marking frame completion.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values: tx=1, busy=0, done=0, hold register empty, state IDLE, counters 0. This makes data_ready=1.
- data_ready = !hold_full, decoded directly from a register; it does not depend on data_valid.
- FSM states: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE:
  - tx=1, busy=0.
  - On handshake: load data_in straight into the shift register (the hold register stays empty), set tx<=0, go to START.
  - tx is therefore low from the cycle after the handshake.
- START: tx=0 for exactly T cycles, then go to DATA with bit index 0.
- DATA:
  - tx = shift[0] for T cycles per bit, LSB first.
  - After bit DATA_WIDTH-1, go to PARITY or STOP.
- STOP:
  - tx=1 for STOP_BITS*T cycles.
  - done=1 during the last cycle of the final stop bit only.
- Frame end (the edge closing the last stop cycle):
  - Hold full: move hold into the shifter, clear hold_full, tx<=0, go to START. No idle gap.
  - Hold empty and a handshake on that same edge: load data_in directly, go to START. No gap.
  - Otherwise: go to IDLE, busy<=0.
- busy is 1 in every non-IDLE state.
- While busy, a handshake writes data_in to the hold register and sets hold_full, which drops data_ready the next cycle. A second word is held off until the frame ends.
- data_in is don't-care when there is no handshake; the transmitted frame is unaffected by data_in changes after capture.
- Bit counter: counts 0..T-1 and wraps to 0 on every bit boundary; it must not drift across frames.
- Reset mid-frame: tx goes to 1 immediately (asynchronous). The in-flight word and any held word are discarded. done is not pulsed.
- data_valid deasserted mid-frame has no effect on the frame.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- When defined:
  - A PARITY state follows DATA.
  - tx = even parity (XOR of the data bits) for T cycles, then go to STOP.
  - Frame length becomes 1+DATA_WIDTH+1+STOP_BITS bit periods.
- When undefined: the PARITY state and its logic are absent; DATA goes directly to STOP.

Test Plan:
- Use CLK_FREQ=1_000_000 and BAUD_RATE=100_000, so T=10. Cycle 0 is the handshake edge.
- 1. Single word: send 0xA5 with STOP_BITS=1 ->
  - tx low cycles 1-10;
  - data bits 1,0,1,0,0,1,0,1 in 10-cycle slots over cycles 11-90;
  - tx high cycles 91-100;
  - done=1 only in cycle 100; busy low from cycle 101.
- 2. Back-to-back: 0x00, then 0xFF handshaken at cycle 5 ->
  - data_ready=0 from cycle 6 through cycle 100;
  - second start bit at cycle 101; no high gap beyond one stop bit;
  - two done pulses, cycles 100 and 200.
- 3. STOP_BITS=2: send 0x3C -> stop high cycles 91-110; done in cycle 110; total frame 110 cycles.
- 4. Parity (macro defined): send 0x07 -> parity slot at cycles 91-100 with tx=1; stop at 101-110; done in cycle 110.
- 5. Reset mid-frame: assert rst_n=0 at cycle 45 with hold full ->
  - tx=1, busy=0, data_ready=1 asynchronously;
  - after release, a new 0x5A frame is sent correctly from its handshake.
- 6. Valid held low: data_valid=0 for 500 cycles after reset -> tx stays 1, busy=0, done never pulses, data_ready stays 1.
